cpu_program_sequencer: RTL and testbench
========================================

// Module: cpu_program_sequencer
// PURPOSE
// - Instruction-issuing master for the 4-bit accumulator CPU: buffers a short program, then drives the
//   CPU's ui_in/uio_in pin bundle one instruction at a time.
// - Holds each instruction long enough for the CPU's registered decode/execute path, then returns the
//   CPU to idle with a NOP, samples the accumulator and streams each result out.
// - Sits between a host/test controller and the CPU pins, on the same clk/rst.
// PARAMETERS
// - DEPTH        16  program buffer entries; power of two, 2..16
// - HOLD_CYCLES   3  cycles each instruction is driven on the CPU pins; >=1
// - GAP_CYCLES    3  cycles NOP is driven after each instruction before the accumulator is sampled; >=1
// PORTS
// - clk         in   1   clock
// - rst         in   1   reset, asynchronous, active-high
// - ld_valid    in   1   program-load request
// - ld_instr    in   13  {we, opcode[3:0], data[3:0], addr[3:0]}
// - ld_ready    out  1   buffer accepts ld_instr this cycle
// - clear       in   1   empty the program buffer; honoured only in IDLE
// - start       in   1   1-cycle pulse: run the buffered program from entry 0
// - busy        out  1   high from the cycle after an accepted start until done
// - cpu_ui      out  8   to CPU ui_in = {data, addr}
// - cpu_uio     out  8   to CPU uio_in = {opcode, 3'b000, we}
// - acc_in      in   4   CPU accumulator (uo_out[3:0])
// - res_valid   out  1   1-cycle pulse: res_data/res_index valid
// - res_data    out  4   sampled accumulator
// - res_index   out  4   program entry that produced res_data
// - done        out  1   1-cycle pulse after the last result
// BEHAVIOUR
// - Reset: state=IDLE, count=0, ld_ready=1, busy=0, res_valid=0, done=0, res_data=0, res_index=0.
//   cpu_ui=8'h00; cpu_uio=8'hF0 (NOP: opcode 4'b1111, we=0).
// - Reset asserted mid-run aborts immediately; the buffer contents are lost (count=0).
// - NOP opcode 4'b1111 keeps the CPU FSM in its IDLE state.
// - Load: transfer when ld_valid && ld_ready; stores buf[count] and does count+1.
//   ld_ready = (state==IDLE) && (count<DEPTH).
//   When full, ld_ready=0; further ld_valid is ignored and count stays at DEPTH with no wrap.
// - clear in IDLE: count<=0 next cycle. If clear and a load occur in the same cycle, clear wins and
//   the load is dropped. clear outside IDLE is ignored.
// - start in IDLE with count==0: no run; done pulses the next cycle and busy stays 0.
// - start outside IDLE is ignored. start and ld_valid in the same IDLE cycle: the load is accepted
//   first, and the run includes the new entry.
// - FSM states:
//   - IDLE: accept start -> ISSUE, ptr=0.
//   - ISSUE: drive buf[ptr] fields on cpu_ui/cpu_uio for HOLD_CYCLES cycles -> GAP.
//   - GAP: drive NOP (cpu_ui data/addr held from the instruction, so STORE/LOAD address stays stable)
//     for GAP_CYCLES cycles.
//     - On the final GAP cycle, register res_data<=acc_in and res_index<=ptr.
//     - res_valid=1 the following cycle.
//     - If ptr==count-1 -> DONE; otherwise ptr+1 -> ISSUE.
//   - DONE: done=1 for one cycle, cpu pins at reset values -> IDLE.
// - Per-instruction latency: HOLD_CYCLES+GAP_CYCLES cycles; res_valid follows one cycle after the
//   sample. busy=1 in ISSUE/GAP/DONE.
// - All outputs are registered; cpu pins change only on clk edges.
// - ptr and the cycle counters are sized $clog2 of their maxima +1; there is no wrap beyond count-1.
// - The buffer is preserved across runs, so start can be re-issued to re-run the program.
// TESTING
// - Reset, then load {0,0011,0000,0101} and start: cpu_uio=8'h30 for 3 cycles, then 8'hF0;
//   res_index=0 with res_data = the model acc; done 1 cycle later.
// - Load 16 entries: ld_ready drops after the 16th; a 17th ld_valid leaves count=16;
//   the run emits res_index 0..15 in order, then one done.
// - Program ADD 5 (0000/0101), ADD 4, SUB 2 with a CPU model attached: res_data = 5, 9, 7.
// - start with an empty buffer -> done the next cycle, no res_valid, busy stays 0.
// - start or ld_valid during a run -> ignored: ld_ready=0, the result sequence is unchanged,
//   and count is unchanged.
// - rst mid-run (during GAP of entry 1) -> all outputs at reset values next cycle; count=0;
//   a subsequent start gives an immediate done.

Source files
------------

// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer: buffers a short program, issues it to the accumulator CPU and streams results
module cpu_program_sequencer #(
  parameter int DEPTH = 16,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [12:0] ld_instr,
  output logic        ld_ready,
  input  logic        clear,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  cpu_ui,
  output logic [7:0]  cpu_uio,
  input  logic [3:0]  acc_in,
  output logic        res_valid,
  output logic [3:0]  res_data,
  output logic [3:0]  res_index,
  output logic        done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int MC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(MC) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, ptr, ptr_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [12:0] mem [DEPTH];
  logic [12:0] ins_n;
  logic [7:0] ui_n, uio_n;
  logic load, go, empty, hold_end, gap_end, last;
  assign ld_ready = state == IDLE && count < CW'(DEPTH);
  assign busy = state != IDLE;
  assign load = ld_valid && ld_ready && !clear;
  assign hold_end = cnt == TW'(HOLD_CYCLES - 1);
  assign gap_end = cnt == TW'(GAP_CYCLES - 1);
  assign last = ptr == count - CW'(1);
  // next state, pointer/cycle counters and the pin values for the coming cycle
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    count_n = state == IDLE && clear ? '0 : count + CW'(load);
    go = state == IDLE && start && count_n != '0;
    empty = state == IDLE && start && count_n == '0;
    case (state)
      IDLE: if (go) begin
        state_n = ISSUE;
        ptr_n = '0;
        cnt_n = '0;
      end
      ISSUE: begin
        state_n = hold_end ? GAP : ISSUE;
        cnt_n = hold_end ? '0 : cnt + TW'(1);
      end
      GAP: begin
        state_n = gap_end ? (last ? DONE : ISSUE) : GAP;
        ptr_n = gap_end && !last ? ptr + CW'(1) : ptr;
        cnt_n = gap_end ? '0 : cnt + TW'(1);
      end
      default: state_n = IDLE;
    endcase
    ins_n = load && count == ptr_n ? ld_instr : mem[ptr_n[CW-2:0]];
    ui_n = state_n == ISSUE || state_n == GAP ? ins_n[7:0] : 8'h00;
    uio_n = state_n == ISSUE ? {ins_n[11:8], 3'b000, ins_n[12]} : 8'hF0;
  end
  // state, counters and registered outputs; reset aborts a run and empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      ptr <= '0;
      cnt <= '0;
      cpu_ui <= 8'h00;
      cpu_uio <= 8'hF0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_index <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      cpu_ui <= ui_n;
      cpu_uio <= uio_n;
      res_valid <= state == GAP && gap_end;
      if (state == GAP && gap_end) begin
        res_data <= acc_in;
        res_index <= 4'(ptr);
      end
      done <= state == DONE || empty;
    end
  end
  // program buffer storage; contents are meaningful only below count
  always_ff @(posedge clk)
    if (load) mem[count[CW-2:0]] <= ld_instr;
endmodule

// File: tb/tb_cpu_program_sequencer.sv
// tb_cpu_program_sequencer: scoreboard bench with a small accumulator CPU model on the pins
module tb_cpu_program_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic ld_valid = 1'b0, clear = 1'b0, start = 1'b0;
  logic [12:0] ld_instr = '0;
  logic ld_ready, busy, res_valid, done;
  logic [7:0] cpu_ui, cpu_uio;
  logic [3:0] acc_in, res_data, res_index;
  logic [3:0] acc = '0, exp_acc;
  logic cbusy = 1'b0;
  logic [7:0] sb [$];
  logic [12:0] prog [3];
  int checks = 0, failures = 0, res_cnt = 0;

  cpu_program_sequencer dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_instr(ld_instr), .ld_ready(ld_ready),
    .clear(clear), .start(start), .busy(busy), .cpu_ui(cpu_ui), .cpu_uio(cpu_uio),
    .acc_in(acc_in), .res_valid(res_valid), .res_data(res_data), .res_index(res_index), .done(done)
  );

  always #5 clk = ~clk;

  // CPU model: executes one instruction when leaving idle, returns to idle on NOP
  assign acc_in = acc;
  always @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cbusy <= 1'b0;
    end else if (cpu_uio[7:4] == 4'hF) cbusy <= 1'b0;
    else if (!cbusy) begin
      cbusy <= 1'b1;
      acc <= cpu_uio[7:4] == 4'h0 ? acc + cpu_ui[7:4] : cpu_uio[7:4] == 4'h1 ? acc - cpu_ui[7:4] : acc;
    end

  function automatic logic [3:0] step(input logic [3:0] a, input logic [12:0] i);
    return i[11:8] == 4'h0 ? a + i[7:4] : i[11:8] == 4'h1 ? a - i[7:4] : a;
  endfunction

  // scoreboard: every result pulse must match the oldest expected {index, data}
  always @(negedge clk)
    if (!rst && res_valid) begin
      res_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got idx=%0d data=%0d expected none", res_index, res_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if ({res_index, res_data} !== e) begin
          failures++;
          $display("FAIL result got idx=%0d data=%0d expected idx=%0d data=%0d", res_index, res_data, e[7:4], e[3:0]);
        end
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    exp_acc = '0;
    tick;
  endtask

  task automatic load(input logic [12:0] i);
    ld_valid = 1'b1;
    ld_instr = i;
    tick;
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      tick;
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_done_timeout got done=0 expected done=1", name);
    end
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++;
    if ({ld_ready, busy, res_valid, done, res_data, res_index, cpu_ui, cpu_uio} !== {4'b1000, 8'h00, 8'h00, 8'hF0}) begin
      failures++;
      $display("FAIL reset_outputs got %h expected %h", {ld_ready, busy, res_valid, done, res_data, res_index, cpu_ui, cpu_uio}, {4'b1000, 8'h00, 8'h00, 8'hF0});
    end
    do_reset;
  endtask

  task automatic test_single;
    logic [19:0] e;
    load({1'b0, 4'b0011, 4'b0000, 4'b0101});
    sb.push_back(8'h00);
    pulse_start;
    for (int k = 0; k < 8; k++) begin
      e = k < 3 ? {4'b1000, 8'h05, 8'h30} : k < 6 ? {4'b1000, 8'h05, 8'hF0} : k == 6 ? {4'b1100, 8'h00, 8'hF0} : {4'b0010, 8'h00, 8'hF0};
      checks++;
      if ({busy, res_valid, done, 1'b0, cpu_ui, cpu_uio} !== e) begin
        failures++;
        $display("FAIL single_cycle%0d got %h expected %h", k, {busy, res_valid, done, 1'b0, cpu_ui, cpu_uio}, e);
      end
      tick;
    end
  endtask

  task automatic test_full;
    logic [12:0] i;
    int r0, op;
    do_reset;
    for (int k = 0; k < 16; k++) begin
      op = $urandom_range(0, 2);
      i = {1'b0, op == 2 ? 4'h3 : 4'(op), 4'($urandom_range(0, 15)), 4'(k)};
      exp_acc = step(exp_acc, i);
      sb.push_back({4'(k), exp_acc});
      load(i);
    end
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ld_ready got %b expected 0", ld_ready);
    end
    load({1'b0, 4'h0, 4'hF, 4'h0});
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_overflow_ld_ready got %b expected 0", ld_ready);
    end
    r0 = res_cnt;
    pulse_start;
    wait_done("full");
    checks++;
    if (res_cnt - r0 !== 16 || sb.size() != 0) begin
      failures++;
      $display("FAIL full_result_count got %0d expected 16 (pending %0d)", res_cnt - r0, sb.size());
    end
  endtask

  task automatic test_empty;
    int r0;
    do_reset;
    r0 = res_cnt;
    pulse_start;
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL empty_start got done,busy=%b expected 10", {done, busy});
    end
    load(13'h0101);
    load(13'h0102);
    clear = 1'b1;
    ld_valid = 1'b1;
    tick;
    clear = 1'b0;
    ld_valid = 1'b0;
    pulse_start;
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL clear_start got done,busy=%b expected 10", {done, busy});
    end
    tick;
    tick;
    checks++;
    if (res_cnt != r0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_no_results got results=%0d busy=%b expected 0 0", res_cnt - r0, busy);
    end
  endtask

  task automatic test_add_sub;
    int r0;
    do_reset;
    foreach (prog[k]) load(prog[k]);
    sb.push_back(8'h05);
    sb.push_back(8'h19);
    sb.push_back(8'h27);
    exp_acc = 4'd7;
    r0 = res_cnt;
    pulse_start;
    wait_done("add_sub");
    checks++;
    if (res_cnt - r0 !== 3) begin
      failures++;
      $display("FAIL add_sub_count got %0d expected 3", res_cnt - r0);
    end
  endtask

  task automatic test_busy_ignore;
    int r0;
    for (int run = 0; run < 2; run++) begin
      foreach (prog[k]) begin
        exp_acc = step(exp_acc, prog[k]);
        sb.push_back({4'(k), exp_acc});
      end
      r0 = res_cnt;
      pulse_start;
      tick;
      if (run == 0) begin
        start = 1'b1;
        ld_valid = 1'b1;
        ld_instr = {1'b0, 4'h0, 4'h1, 4'h0};
        checks++;
        if (ld_ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_ld_ready got %b expected 0", ld_ready);
        end
        tick;
        start = 1'b0;
        ld_valid = 1'b0;
      end
      wait_done("busy_ignore");
      checks++;
      if (res_cnt - r0 !== 3 || sb.size() != 0) begin
        failures++;
        $display("FAIL busy_ignore_run%0d_count got %0d expected 3", run, res_cnt - r0);
      end
    end
  endtask

  task automatic test_rst_mid;
    int r0;
    sb.push_back({4'h0, step(exp_acc, prog[0])});
    pulse_start;
    for (int k = 0; k < 10; k++) tick;
    rst = 1'b1;
    #1;
    checks++;
    if ({ld_ready, busy, res_valid, done, res_data, res_index, cpu_ui, cpu_uio} !== {4'b1000, 8'h00, 8'h00, 8'hF0}) begin
      failures++;
      $display("FAIL rst_mid_outputs got %h expected %h", {ld_ready, busy, res_valid, done, res_data, res_index, cpu_ui, cpu_uio}, {4'b1000, 8'h00, 8'h00, 8'hF0});
    end
    tick;
    rst = 1'b0;
    exp_acc = '0;
    tick;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_entry0 got pending=%0d expected 0", sb.size());
      sb.delete();
    end
    r0 = res_cnt;
    pulse_start;
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_start got done,busy=%b expected 10", {done, busy});
    end
    tick;
    tick;
    checks++;
    if (res_cnt != r0) begin
      failures++;
      $display("FAIL rst_mid_no_results got %0d expected 0", res_cnt - r0);
    end
  endtask

  initial begin
    prog[0] = {1'b0, 4'h0, 4'd5, 4'h0};
    prog[1] = {1'b0, 4'h0, 4'd4, 4'h1};
    prog[2] = {1'b0, 4'h1, 4'd2, 4'h2};
    test_reset;
    test_single;
    test_full;
    test_empty;
    test_add_sub;
    test_busy_ignore;
    test_rst_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
